// File: rtl/trace_sequencer.sv
// Trace-record sequencer: buffers R/W trace records in a FIFO and presents them one
// at a time to a cache engine, with a bounded wait for retirement and saturating stats.
module trace_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_op,
    input  logic [47:0]              in_addr,
    output logic [47:0]              cache_addr,
    output logic [7:0]               cache_op,
    output logic                     issue,
    input  logic                     eng_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [11:0]              rd_count,
    output logic [11:0]              wr_count,
    output logic [11:0]              drop_count,
    output logic [11:0]              timeout_count
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_EMPTY = (AW+1)'(0);
    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [7:0]    OP_RD     = 8'h52;
    localparam logic [7:0]    OP_WR     = 8'h57;
    localparam logic [7:0]    TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [11:0]   CNT_MAX   = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_COOL  = 2'd3
    } state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] value);
        return (value == CNT_MAX) ? value : value + 12'd1;
    endfunction

    state_t         state_q;
    logic [AW:0]    level_q;
    logic [AW:0]    level_d;
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  wptr_d;
    logic [AW-1:0]  rptr_q;
    logic [AW-1:0]  rptr_d;
    logic [55:0]    mem_q [DEPTH];
    logic [7:0]     timer_q;
    logic [47:0]    cache_addr_q;
    logic [7:0]     cache_op_q;
    logic           issue_q;
    logic           busy_q;
    logic [11:0]    rd_cnt_q;
    logic [11:0]    wr_cnt_q;
    logic [11:0]    tmo_cnt_q;
    logic [11:0]    drop_cnt_q;

    logic           accept_s;
    logic           op_ok_s;
    logic           push_s;
    logic           drop_s;
    logic           pop_s;
    logic [55:0]    head_s;

    assign in_ready = (level_q != LVL_FULL);
    assign accept_s = in_valid && in_ready;
    assign op_ok_s  = (in_op == OP_RD) || (in_op == OP_WR);
    assign push_s   = accept_s && op_ok_s;
    assign drop_s   = accept_s && !op_ok_s;
    assign pop_s    = (state_q == ST_IDLE) && (level_q != LVL_EMPTY);
    assign head_s   = mem_q[rptr_q];

    // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= PTR_ZERO;
            rptr_q  <= PTR_ZERO;
            level_q <= LVL_EMPTY;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Record storage; contents are only read behind a nonzero level, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= {in_op, in_addr};
        end
    end

    // Count records accepted with an unrecognised operation byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= 12'd0;
        end else if (drop_s) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    // Request FSM with registered request, pulse, busy and retirement statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= 8'd0;
            cache_addr_q <= 48'h0;
            cache_op_q   <= 8'h00;
            issue_q      <= 1'b0;
            busy_q       <= 1'b0;
            rd_cnt_q     <= 12'd0;
            wr_cnt_q     <= 12'd0;
            tmo_cnt_q    <= 12'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        cache_op_q   <= head_s[55:48];
                        cache_addr_q <= head_s[47:0];
                        issue_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ISSUE;
                        if (head_s[55:48] == OP_RD) begin
                            rd_cnt_q <= sat_inc(rd_cnt_q);
                        end else if (head_s[55:48] == OP_WR) begin
                            wr_cnt_q <= sat_inc(wr_cnt_q);
                        end
                    end
                end
                ST_ISSUE: begin
                    issue_q <= 1'b0;
                    timer_q <= 8'd0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Retirement takes priority over a timeout landing on the same edge
                    if (eng_done) begin
                        state_q <= ST_COOL;
                    end else if (timer_q == TMO_LAST) begin
                        timer_q   <= timer_q + 8'd1;
                        tmo_cnt_q <= sat_inc(tmo_cnt_q);
                        state_q   <= ST_COOL;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                ST_COOL: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    issue_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cache_addr    = cache_addr_q;
    assign cache_op      = cache_op_q;
    assign issue         = issue_q;
    assign busy          = busy_q;
    assign fifo_level    = level_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;
    assign drop_count    = drop_cnt_q;
    assign timeout_count = tmo_cnt_q;

endmodule

// File: doc/trace_sequencer.md
TRACE_SEQUENCER -- requirements
Module: trace_sequencer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning the number of trace-record FIFO entries (a power of two, at least 2).
REQ-002 The module SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles before a forced retire (range 1..255).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the upstream trace record is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the module can accept a record.
REQ-007 The module SHALL have port in_op, input, 8 bits: the record operation byte, 8'h52 'R' or 8'h57 'W'.
REQ-008 The module SHALL have port in_addr, input, 48 bits: the record byte address.
REQ-009 The module SHALL have port cache_addr, output, 48 bits: the address presented to the cache engine.
REQ-010 The module SHALL have port cache_op, output, 8 bits: the operation presented to the cache engine.
REQ-011 The module SHALL have port issue, output, 1 bit: a one-cycle pulse marking a newly presented request.
REQ-012 The module SHALL have port eng_done, input, 1 bit: the engine has retired the current request.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The module SHALL have port fifo_level, output, $clog2(DEPTH)+1 bits: the current FIFO occupancy.
REQ-015 The module SHALL have ports rd_count, wr_count, drop_count and timeout_count, each an output of 12 bits: the statistics counters.

Function
REQ-016 The module SHALL assert in_ready = (fifo_level != DEPTH), combinationally from the registered level only.
REQ-017 When in_valid and in_ready are both high and in_op is 8'h52 or 8'h57, the module SHALL write {in_op, in_addr} at the FIFO tail.
REQ-018 When in_valid and in_ready are both high and in_op is any other value, the module SHALL accept and discard the record and increment drop_count.
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT and COOL.
REQ-020 In IDLE with fifo_level != 0, at the clock edge the module SHALL pop the head entry into cache_addr/cache_op and go to ISSUE.
REQ-021 The pop in REQ-020 SHALL increment rd_count for 8'h52 and wr_count for 8'h57.
REQ-022 In ISSUE the module SHALL hold issue = 1 for exactly one cycle, clear the wait timer to 0 and go to WAIT.
REQ-023 In WAIT with eng_done = 1, the module SHALL go to COOL.
REQ-024 In WAIT, if the timer reaches TIMEOUT with eng_done = 0, the module SHALL go to COOL and increment timeout_count.
REQ-025 If eng_done and the timeout occur in the same cycle, eng_done SHALL win and timeout_count SHALL NOT change.
REQ-026 In WAIT without retirement, the timer SHALL increment each cycle.
REQ-027 COOL SHALL last exactly one cycle and then go to IDLE; it guarantees the engine sees a stable address before the next change.
REQ-028 eng_done SHALL be ignored in IDLE, ISSUE and COOL.
REQ-029 cache_addr and cache_op SHALL hold their last popped values until the next pop.
REQ-030 The minimum issue-to-issue spacing SHALL be 4 cycles: ISSUE, WAIT with eng_done, COOL, IDLE.
REQ-031 The latency from an accepting edge into an empty FIFO in IDLE to the pop SHALL be 1 edge, with issue high in the following cycle.
REQ-032 Simultaneous push and pop SHALL be legal and leave fifo_level unchanged.
REQ-033 A push SHALL NOT occur when fifo_level == DEPTH, even if a pop happens in the same cycle.
REQ-034 The read and write pointers SHALL wrap modulo DEPTH.
REQ-035 Every statistics counter SHALL saturate at 12'hFFF and never wrap.

Reset
REQ-036 While reset = 0, the module SHALL immediately and asynchronously force: state IDLE, the FIFO pointers and fifo_level to 0, the timer to 0, cache_addr 48'h0, cache_op 8'h00, issue 0, busy 0, and all counters 0.
REQ-037 Reset asserted mid-transaction SHALL discard all FIFO contents and the in-flight request without incrementing any counter.
REQ-038 After reset deasserts, in_ready SHALL be 1 on the first cycle.

Verification
REQ-039 Single read: push {8'h52, 48'h0000_0001_2340}, then eng_done 3 cycles after issue -> one issue pulse, cache_addr = 48'h12340, rd_count = 1, busy falls after COOL.
REQ-040 Fill and wrap: push 10 valid writes with eng_done stuck at 0 -> in_ready falls at fifo_level = 8, and wr_count reaches 10 after drain with TIMEOUT forced retires.
REQ-041 Timeout: one record with eng_done never asserted -> exactly TIMEOUT WAIT cycles, timeout_count = 1, then IDLE.
REQ-042 Invalid op: push in_op 8'h41 -> accepted, drop_count = 1, fifo_level stays 0, no issue pulse.
REQ-043 Simultaneous events: push while popping at fifo_level = 3 -> level stays 3; eng_done coincides with the timer reaching TIMEOUT -> timeout_count unchanged.
REQ-044 Reset mid-WAIT with 5 queued entries -> all outputs return to their reset values at once, and no issue pulse follows reset deassertion.
